// File: rtl/gray_window_3x3_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_window_3x3_if
// Purpose  : Pixel-in / window-out stream bundle for gray_window_3x3.
// Revision : 1.0 - initial release
// ============================================================================
interface gray_window_3x3_if #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 9
);
    logic                  sof_in;
    logic                  pix_valid_in;
    logic [DATA_W-1:0]     pix_in;
    logic                  win_valid;
    logic [9*DATA_W-1:0]   win_out;
    logic [COL_W-1:0]      win_x;
    logic [ROW_W-1:0]      win_y;

    modport master (
        output sof_in, pix_valid_in, pix_in,
        input  win_valid, win_out, win_x, win_y
    );

    modport slave (
        input  sof_in, pix_valid_in, pix_in,
        output win_valid, win_out, win_x, win_y
    );
endinterface
`default_nettype wire

// File: rtl/gray_window_3x3.sv
`default_nettype none
// ============================================================================
// Module   : gray_window_3x3
// Purpose  : Two-line-buffer 3x3 neighbourhood generator for raster grayscale.
// Revision : 1.0 - initial release
// ============================================================================
module gray_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_window_3x3_if.slave        bus
);
    localparam int               c_lb_aw    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [DATA_W-1:0]     r_lb1 [IMG_WIDTH];
    logic [DATA_W-1:0]     r_lb2 [IMG_WIDTH];
    // Only the two newest columns are kept; the oldest column lives in win_out.
    logic [DATA_W-1:0]     r_sh [3][2];

    logic                  r_win_valid;
    logic [9*DATA_W-1:0]   r_win_out;
    logic [COL_W-1:0]      r_win_x;
    logic [ROW_W-1:0]      r_win_y;

    logic                  w_acc;
    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic [c_lb_aw-1:0]    w_lb_addr;
    logic [DATA_W-1:0]     w_lb1_rd;
    logic [DATA_W-1:0]     w_lb2_rd;
    logic                  w_win_ok;
    logic [9*DATA_W-1:0]   w_win_next;

    assign w_acc     = bus.pix_valid_in;
    assign w_col     = bus.sof_in ? '0 : r_col;
    assign w_row     = bus.sof_in ? '0 : r_row;
    assign w_lb_addr = w_col[c_lb_aw-1:0];
    assign w_lb1_rd  = r_lb1[w_lb_addr];
    assign w_lb2_rd  = r_lb2[w_lb_addr];
    assign w_win_ok  = w_acc && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

    // Window as it stands after this beat's shift; p00 sits in the LSBs.
    assign w_win_next = {bus.pix_in, r_sh[2][1], r_sh[2][0],
                         w_lb1_rd,   r_sh[1][1], r_sh[1][0],
                         w_lb2_rd,   r_sh[0][1], r_sh[0][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            if (w_col == c_col_last) begin
                r_col <= '0;
                r_row <= (w_row == c_row_last) ? '0 : w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    // Line RAM is not reset; row gating hides its stale contents.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_lb2[w_lb_addr] <= w_lb1_rd;
            r_lb1[w_lb_addr] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    r_sh[r][c] <= '0;
                end
            end
        end else if (w_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_sh[r][0] <= r_sh[r][1];
            end
            r_sh[0][1] <= w_lb2_rd;
            r_sh[1][1] <= w_lb1_rd;
            r_sh[2][1] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_out   <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end else begin
            r_win_valid <= w_win_ok;
            if (w_win_ok) begin
                r_win_out <= w_win_next;
                r_win_x   <= w_col - COL_W'(1);
                r_win_y   <= w_row - ROW_W'(1);
            end
        end
    end

    assign bus.win_valid = r_win_valid;
    assign bus.win_out   = r_win_out;
    assign bus.win_x     = r_win_x;
    assign bus.win_y     = r_win_y;

endmodule
`default_nettype wire

// File: tb/tb_gray_window_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_window_3x3
// Purpose  : Scoreboard bench for gray_window_3x3 on a 4x4 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_window_3x3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam logic [9*DW-1:0] c_first_win = 72'h22_21_20_12_11_10_02_01_00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_window_3x3_if #(.DATA_W(DW), .COL_W(CW), .ROW_W(RW)) bus ();

    gray_window_3x3 #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW), .COL_W(CW), .ROW_W(RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [CW-1:0]   x;
        logic [RW-1:0]   y;
    } exp_t;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [CW-1:0]   x;
        logic [RW-1:0]   y;
        int              acc;
    } log_t;

    exp_t        exp_q[$];
    log_t        log_q[$];
    exp_t        mon_e;
    log_t        mon_l;
    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] img [H][W];
    int          trow = 0;
    int          tcol = 0;
    int          acc_cnt;
    logic        last_acc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Accept tracker: counts beats since the last sof/reset.
    always @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= 0;
            last_acc <= 1'b0;
        end else begin
            last_acc <= bus.pix_valid_in;
            if (bus.pix_valid_in) acc_cnt <= bus.sof_in ? 1 : acc_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.win_valid === 1'b1) begin
            chk("valid_follows_accept", {127'd0, last_acc}, 128'd1);
            mon_l.win = bus.win_out;
            mon_l.x   = bus.win_x;
            mon_l.y   = bus.win_y;
            mon_l.acc = acc_cnt;
            log_q.push_back(mon_l);
            if (exp_q.size() == 0) begin
                chk("unexpected_window", 128'd1, 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("win_out", bus.win_out, mon_e.win);
                chk("win_x",   bus.win_x,   mon_e.x);
                chk("win_y",   bus.win_y,   mon_e.y);
            end
        end
    end

    task automatic drive(input logic sof, input logic [DW-1:0] px);
        exp_t e;
        @(posedge clk); #1;
        bus.sof_in       = sof;
        bus.pix_valid_in = 1'b1;
        bus.pix_in       = px;
        if (sof) begin
            trow = 0;
            tcol = 0;
        end
        img[trow][tcol] = px;
        if (trow >= 2 && tcol >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    e.win[DW*(3*r+c) +: DW] = img[trow-2+r][tcol-2+c];
                end
            end
            e.x = CW'(tcol - 1);
            e.y = RW'(trow - 1);
            exp_q.push_back(e);
        end
        if (tcol == W - 1) begin
            tcol = 0;
            trow = (trow == H - 1) ? 0 : trow + 1;
        end else begin
            tcol++;
        end
    endtask

    task automatic idle(input logic sof);
        @(posedge clk); #1;
        bus.sof_in       = sof;
        bus.pix_valid_in = 1'b0;
        bus.pix_in       = DW'($urandom);
    endtask

    task automatic frame(input int off, input bit sof_first, input bit gaps, input bit sof_glitch);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(1) == 1) repeat ($urandom_range(1, 2)) idle(1'b0);
                if (sof_glitch && ((r == 1 && c == 2) || (r == 2 && c == 1))) idle(1'b1);
                drive(sof_first && r == 0 && c == 0, DW'(16 * r + c + off));
            end
        end
    endtask

    task automatic drain();
        repeat (3) idle(1'b0);
        chk("queue_empty", exp_q.size(), 128'd0);
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, bus.win_valid, 128'd0);
        chk({tag, "_out"},   bus.win_out,   128'd0);
        chk({tag, "_x"},     bus.win_x,     128'd0);
        chk({tag, "_y"},     bus.win_y,     128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int base;

    initial begin
        rst              = 1'b1;
        bus.sof_in       = 1'b0;
        bus.pix_valid_in = 1'b0;
        bus.pix_in       = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_zero_outputs("reset");

        // Continuous frame; first window after the 11th accept.
        base = log_q.size();
        frame(0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("s1_count", log_q.size() - base, 128'd4);
        if (log_q.size() > base) begin
            chk("s1_first_win", log_q[base].win, c_first_win);
            chk("s1_first_x",   log_q[base].x,   128'd1);
            chk("s1_first_y",   log_q[base].y,   128'd1);
            chk("s1_first_acc", log_q[base].acc, 128'd11);
        end

        // Same frame with random idle gaps.
        base = log_q.size();
        frame(0, 1'b1, 1'b1, 1'b0);
        drain();
        chk("s2_count", log_q.size() - base, 128'd4);

        // Three back-to-back frames; only the first carries sof.
        base = log_q.size();
        frame(0,    1'b1, 1'b0, 1'b0);
        frame(8'h40, 1'b0, 1'b0, 1'b0);
        frame(8'h80, 1'b0, 1'b0, 1'b0);
        drain();
        chk("s3_count", log_q.size() - base, 128'd12);
        if (log_q.size() >= base + 12) begin
            chk("s3_f2_p00", log_q[base+4].win[DW-1:0], 128'h40);
            chk("s3_f3_p00", log_q[base+8].win[DW-1:0], 128'h80);
        end

        // Resync: sof on the pixel that would be (1,3).
        base = log_q.size();
        drive(1'b1, 8'h00);
        for (int i = 1; i < 7; i++) drive(1'b0, DW'(16 * (i / W) + (i % W)));
        frame(8'hA0, 1'b1, 1'b0, 1'b0);
        drain();
        chk("s4_count", log_q.size() - base, 128'd4);
        if (log_q.size() > base) begin
            chk("s4_first_acc", log_q[base].acc, 128'd11);
            chk("s4_first_x",   log_q[base].x,   128'd1);
            chk("s4_first_y",   log_q[base].y,   128'd1);
            chk("s4_first_p00", log_q[base].win[DW-1:0], 128'hA0);
        end

        // Reset after 7 accepts, then a frame without sof.
        for (int i = 0; i < 7; i++) drive(i == 0, DW'(8'h10 + i));
        @(posedge clk); #1;
        rst              = 1'b1;
        bus.pix_valid_in = 1'b0;
        bus.sof_in       = 1'b0;
        @(posedge clk); #1;
        rst  = 1'b0;
        trow = 0;
        tcol = 0;
        exp_q.delete();
        check_zero_outputs("midreset");
        base = log_q.size();
        frame(0, 1'b0, 1'b0, 1'b0);
        drain();
        chk("s5_count", log_q.size() - base, 128'd4);
        if (log_q.size() > base) begin
            chk("s5_first_win", log_q[base].win, c_first_win);
            chk("s5_first_acc", log_q[base].acc, 128'd11);
        end

        // sof without valid mid-frame must be ignored.
        base = log_q.size();
        frame(0, 1'b1, 1'b0, 1'b1);
        drain();
        chk("s6_count", log_q.size() - base, 128'd4);
        if (log_q.size() > base) begin
            chk("s6_first_win", log_q[base].win, c_first_win);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
